// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_pkg
//  Purpose  : Shared field positions, operand-key helpers and the key-match
//             rule used by the dependency-aware dispatch arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package dispatch_pkg;

    // Keys are carried zero-extended into this container for comparison.
    // Supported operand address widths therefore satisfy ADDR_W+1 <= 32.
    localparam int c_key_max_w = 32;

    typedef logic [c_key_max_w-1:0] key_t;

    typedef struct packed {
        key_t src;
        key_t dst;
    } key_pair_t;

    // Flag bit of the source operand (1 = register, 0 = memory).
    function automatic int src_flag_pos(input int aw);
        return 2 * aw + 1;
    endfunction

    // Flag bit of the destination operand.
    function automatic int dst_flag_pos(input int aw);
        return 2 * aw;
    endfunction

    // Lowest bit of the destination address field; source address sits at 0.
    function automatic int dst_addr_lsb(input int aw);
        return aw;
    endfunction

    // A key is the operand flag followed by its address.
    function automatic int key_width(input int aw);
        return aw + 1;
    endfunction

    // RAW, WAR and WAW on the full key (flag included).
    function automatic logic key_conflict(input key_pair_t nk, input key_pair_t ek);
        return (nk.src == ek.dst) || (nk.dst == ek.src) || (nk.dst == ek.dst);
    endfunction

endpackage : dispatch_pkg
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_queue
//  Purpose  : One core channel: instruction + operand-key storage with write,
//             read and retire pointers. Reports whether a presented key pair
//             conflicts with any dispatched-but-unretired entry.
//  Revision : 1.0  initial release
// ============================================================================
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int KW      = 12,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [INSTR_W-1:0]  wr_instr,
    input  logic [KW-1:0]       wr_src,
    input  logic [KW-1:0]       wr_dst,
    input  logic [KW-1:0]       chk_src,
    input  logic [KW-1:0]       chk_dst,
    output logic                conflict,
    output logic                full,
    output logic [CW-1:0]       count,
    output logic                out_valid,
    output logic [INSTR_W-1:0]  out_instr,
    input  logic                out_ready,
    input  logic                retire,
    output logic                retire_err
);

    localparam int c_iw = $clog2(DEPTH);
    localparam int c_pw = c_iw + 1;

    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_pw-1:0]    r_ret_ptr;
    logic               r_retire_err;
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [KW-1:0]      r_mem_src   [DEPTH];
    logic [KW-1:0]      r_mem_dst   [DEPTH];

    logic [c_pw-1:0]    w_count;
    logic [DEPTH-1:0]   w_live;
    logic               w_conflict;
    key_pair_t          w_new_key;

    assign w_count    = r_wr_ptr - r_ret_ptr;
    assign full       = (w_count == c_pw'(DEPTH));
    assign count      = CW'(w_count);
    assign out_valid  = (r_rd_ptr != r_wr_ptr);
    assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr[c_iw-1:0]] : '0;
    assign retire_err = r_retire_err;
    assign conflict   = w_conflict;
    assign w_new_key  = '{src: key_t'(chk_src), dst: key_t'(chk_dst)};

    // Mark every slot between ret_ptr and wr_ptr, read or not, as live.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i] = ({1'b0, (c_iw'(i) - r_ret_ptr[c_iw-1:0])} < w_count);
        end
    end

    // OR of key matches over the live slots.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] &&
                key_conflict(w_new_key, '{src: key_t'(r_mem_src[i]), dst: key_t'(r_mem_dst[i])})) begin
                w_conflict = 1'b1;
            end
        end
    end

    // Pointer advance for accept, read and retire; all three may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ret_ptr    <= '0;
            r_retire_err <= 1'b0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (out_valid && out_ready) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (retire) begin
                if (r_ret_ptr != r_rd_ptr) begin
                    r_ret_ptr <= r_ret_ptr + 1'b1;
                end else begin
                    r_retire_err <= 1'b1;
                end
            end
        end
    end

    // Entry storage; contents are only trusted inside the live window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_instr[r_wr_ptr[c_iw-1:0]] <= wr_instr;
            r_mem_src[r_wr_ptr[c_iw-1:0]]   <= wr_src;
            r_mem_dst[r_wr_ptr[c_iw-1:0]]   <= wr_dst;
        end
    end

endmodule : dispatch_queue
`default_nettype wire

// File: rtl/dep_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dep_dispatch_arbiter
//  Purpose  : Dispatches one instruction per cycle to N_CH core queues,
//             steering memory operations that depend on in-flight work to
//             the channel holding that work, round-robin otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module dep_dispatch_arbiter
    import dispatch_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 11
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [INSTR_W-1:0]               in_instr,
    output logic                             in_ready,
    output logic [N_CH-1:0]                  out_valid,
    output logic [N_CH*INSTR_W-1:0]          out_instr,
    input  logic [N_CH-1:0]                  out_ready,
    input  logic [N_CH-1:0]                  retire,
    output logic                             hazard_stall,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]  ch_count,
    output logic [N_CH-1:0]                  retire_err
);

    localparam int c_kw       = key_width(ADDR_W);
    localparam int c_cw       = $clog2(DEPTH + 1);
    localparam int c_rr_w     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_pc_w     = $clog2(N_CH + 1);
    localparam int c_src_flag = src_flag_pos(ADDR_W);
    localparam int c_dst_flag = dst_flag_pos(ADDR_W);
    localparam int c_dst_lsb  = dst_addr_lsb(ADDR_W);

    logic [c_rr_w-1:0] r_rr;

    logic [c_kw-1:0]   w_src_key;
    logic [c_kw-1:0]   w_dst_key;
    logic              w_mem_op;
    logic [N_CH-1:0]   w_hit;
    logic [N_CH-1:0]   w_cvec;
    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_wr_en;
    logic [c_pc_w-1:0] w_popcnt;
    logic [c_rr_w-1:0] w_cidx;
    logic [c_rr_w-1:0] w_scan_idx;
    logic [c_rr_w-1:0] w_rr_idx;
    logic              w_rr_found;
    logic [c_rr_w-1:0] w_target;
    logic              w_has_target;
    logic              w_accept;

    assign w_src_key = {in_instr[c_src_flag], in_instr[ADDR_W-1:0]};
    assign w_dst_key = {in_instr[c_dst_flag], in_instr[c_dst_lsb +: ADDR_W]};
    assign w_mem_op  = !in_instr[c_src_flag] || !in_instr[c_dst_flag];
    assign w_cvec    = w_mem_op ? w_hit : '0;

    // Count conflicting channels and remember the (only meaningful) last one.
    always_comb begin
        w_popcnt = '0;
        w_cidx   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_cvec[c]) begin
                w_popcnt = w_popcnt + c_pc_w'(1);
                w_cidx   = c_rr_w'(c);
            end
        end
    end

    // First non-full channel at or after rr, with wrap.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_scan_idx = c_rr_w'((int'(r_rr) + i) % N_CH);
            if (!w_rr_found && !w_full[w_scan_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan_idx;
            end
        end
    end

    // Target choice: free round-robin, forced single channel, or none.
    always_comb begin
        w_has_target = 1'b0;
        w_target     = '0;
        if (w_popcnt == '0) begin
            w_has_target = w_rr_found;
            w_target     = w_rr_idx;
        end else if (w_popcnt == c_pc_w'(1)) begin
            w_has_target = 1'b1;
            w_target     = w_cidx;
        end
    end

    assign in_ready     = !reset && w_has_target && !w_full[w_target];
    assign hazard_stall = !reset && in_valid && (w_popcnt >= c_pc_w'(2));
    assign w_accept     = in_valid && in_ready;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            assign w_wr_en[g] = w_accept && (w_target == c_rr_w'(g));

            dispatch_queue #(
                .DEPTH   (DEPTH),
                .INSTR_W (INSTR_W),
                .KW      (c_kw),
                .CW      (c_cw)
            ) u_queue (
                .clk        (clk),
                .reset      (reset),
                .wr_en      (w_wr_en[g]),
                .wr_instr   (in_instr),
                .wr_src     (w_src_key),
                .wr_dst     (w_dst_key),
                .chk_src    (w_src_key),
                .chk_dst    (w_dst_key),
                .conflict   (w_hit[g]),
                .full       (w_full[g]),
                .count      (ch_count[g*c_cw +: c_cw]),
                .out_valid  (out_valid[g]),
                .out_instr  (out_instr[g*INSTR_W +: INSTR_W]),
                .out_ready  (out_ready[g]),
                .retire     (retire[g]),
                .retire_err (retire_err[g])
            );
        end
    endgenerate

    // Round-robin pointer moves only on conflict-free accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr <= '0;
        end else if (w_accept && (w_popcnt == '0)) begin
            r_rr <= (w_target == c_rr_w'(N_CH - 1)) ? '0 : w_target + 1'b1;
        end
    end

endmodule : dep_dispatch_arbiter
`default_nettype wire
